// File: rtl/uart_slip_top.sv
// Host-link receive path: 8N1 UART receiver, SLIP frame decoder, and a one-byte
// UART acknowledge carrying the payload length of each good frame.
module uart_slip_top #(
    parameter int BIT_CLKS = 32,
    parameter int MAX_LEN  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       frame_end,
    output logic       frame_err,
    output logic [7:0] frame_len,
    output logic       tx_busy
);

    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CLKS - 1);
    localparam logic [7:0]    MAXL    = 8'(MAX_LEN);
    localparam logic [7:0]    SL_END  = 8'hC0;
    localparam logic [7:0]    SL_ESC  = 8'hDB;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic {DEC_NORMAL, DEC_ESC} dec_state_t;

    logic       sync1, rxs, rx_prev;
    logic [1:0] flush;

    // rx_prev stays low until the synchronizer holds real samples, so a line
    // held low across reset release is never mistaken for a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            rx_prev <= 1'b0;
            flush   <= '0;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            if (flush != 2'd2)
                flush <= flush + 2'd1;
            else
                rx_prev <= rxs;
        end
    end

    rx_state_t       rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_bit, rx_bit_n;
    logic [7:0]      rx_sh, rx_sh_n;
    logic            byte_ok, byte_ok_n;
    logic            rx_ferr, rx_ferr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            byte_ok  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
            byte_ok  <= byte_ok_n;
            rx_ferr  <= rx_ferr_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        byte_ok_n  = 1'b0;
        rx_ferr_n  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rxs)
                    rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rxs, rx_sh[7:1]};
                    rx_bit_n = rx_bit + 1'b1;
                    if (rx_bit == 3'd7)
                        rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_n = '0;
                    if (rxs) begin
                        byte_ok_n  = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_ferr_n  = 1'b1;
                        rx_state_n = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                rx_cnt_n = '0;
                if (rxs)
                    rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    dec_state_t dec_state, dec_state_n;
    logic [7:0] len, len_n;
    logic       err, err_n;
    logic [7:0] dout_n, frame_len_n;
    logic       dout_valid_n, frame_end_n, frame_err_n;
    logic       emit, term, set_err;
    logic [7:0] emit_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_state  <= DEC_NORMAL;
            len        <= '0;
            err        <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_end  <= 1'b0;
            frame_err  <= 1'b0;
            frame_len  <= '0;
        end else begin
            dec_state  <= dec_state_n;
            len        <= len_n;
            err        <= err_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            frame_end  <= frame_end_n;
            frame_err  <= frame_err_n;
            frame_len  <= frame_len_n;
        end
    end

    always_comb begin
        dec_state_n  = dec_state;
        len_n        = len;
        err_n        = err;
        dout_n       = dout;
        dout_valid_n = 1'b0;
        frame_end_n  = 1'b0;
        frame_err_n  = 1'b0;
        frame_len_n  = frame_len;
        emit         = 1'b0;
        term         = 1'b0;
        set_err      = 1'b0;
        emit_byte    = rx_sh;
        if (rx_ferr) begin
            set_err = 1'b1;
        end else if (byte_ok) begin
            if (dec_state == DEC_NORMAL) begin
                if (rx_sh == SL_END)
                    term = 1'b1;
                else if (rx_sh == SL_ESC)
                    dec_state_n = DEC_ESC;
                else
                    emit = 1'b1;
            end else begin
                dec_state_n = DEC_NORMAL;
                case (rx_sh)
                    8'hDC: begin emit = 1'b1; emit_byte = SL_END; end
                    8'hDD: begin emit = 1'b1; emit_byte = SL_ESC; end
                    SL_END: begin set_err = 1'b1; term = 1'b1; end
                    default: set_err = 1'b1;
                endcase
            end
        end
        if (emit) begin
            if (len == MAXL) begin
                set_err = 1'b1;
            end else begin
                dout_n       = emit_byte;
                dout_valid_n = 1'b1;
                len_n        = len + 1'b1;
            end
        end
        if (set_err)
            err_n = 1'b1;
        // ESC+END must see the error it just raised, hence err_n not err.
        if (term) begin
            if (err_n) begin
                frame_err_n = 1'b1;
                frame_len_n = len;
            end else if (len != 8'd0) begin
                frame_end_n = 1'b1;
                frame_len_n = len;
            end
            len_n = '0;
            err_n = 1'b0;
        end
    end

    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '1;
        end else if (!tx_busy) begin
            if (frame_end) begin
                txd     <= 1'b0;
                tx_busy <= 1'b1;
                tx_cnt  <= '0;
                tx_bit  <= '0;
                tx_sh   <= {1'b1, frame_len};
            end
        end else if (tx_cnt == FULL_M1) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                txd    <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[8:1]};
                tx_bit <= tx_bit + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_slip_top.sv
// Scoreboard bench for uart_slip_top: frames are built from SLIP tokens and the
// expected payload, frame reports and length acks are derived from those tokens.
module tb_uart_slip_top;

    localparam int BIT  = 32;
    localparam int MAXL = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       txd;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_end;
    logic       frame_err;
    logic [7:0] frame_len;
    logic       tx_busy;

    always #5 clk = ~clk;

    uart_slip_top #(.BIT_CLKS(BIT), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
        .dout(dout), .dout_valid(dout_valid),
        .frame_end(frame_end), .frame_err(frame_err),
        .frame_len(frame_len), .tx_busy(tx_busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_kind[$];   // 0 = payload byte, 1 = frame_end, 2 = frame_err
    int exp_val[$];
    int ack_q[$];
    int f_cnt = 0;
    int f_err = 0;
    logic ack_chk = 1'b0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_reset_values();
        check("rst_txd", int'(txd), 1);
        check("rst_dout", int'(dout), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_frame_end", int'(frame_end), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_frame_len", int'(frame_len), 0);
        check("rst_tx_busy", int'(tx_busy), 0);
    endtask

    // Output monitor: pops the scoreboard on every strobe.
    always @(negedge clk) begin : out_mon
        int n, kind, val;
        if (!rst) begin
            if (ack_chk) begin
                check("ack_start_latency", int'(txd), 0);
                check("ack_busy", int'(tx_busy), 1);
                ack_chk = 1'b0;
            end
            n = int'(dout_valid) + int'(frame_end) + int'(frame_err);
            if (n > 0) begin
                check("strobe_exclusive", n, 1);
                kind = dout_valid ? 0 : (frame_end ? 1 : 2);
                val  = dout_valid ? int'(dout) : int'(frame_len);
                if (exp_kind.size() == 0) begin
                    check("unexpected_output", kind * 256 + val, -1);
                end else begin
                    check("out_kind", kind, exp_kind.pop_front());
                    check("out_value", val, exp_val.pop_front());
                end
                if (frame_end)
                    ack_chk = 1'b1;
            end
        end
    end

    // Ack monitor: decodes the UART byte on txd.
    initial begin : ack_mon
        logic p;
        logic [7:0] b;
        p = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && p && !txd) begin
                repeat (BIT / 2) @(negedge clk);
                check("ack_start_bit", int'(txd), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                check("ack_stop_bit", int'(txd), 1);
                if (ack_q.size() == 0)
                    check("unexpected_ack", int'(b), -1);
                else
                    check("ack_byte", int'(b), ack_q.pop_front());
            end
            p = txd;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
        if (!stop_ok) repeat (BIT) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic tok_start();
        f_cnt = 0;
        f_err = 0;
        send_byte(8'hC0, 1'b1);
    endtask

    task automatic tok_lit(input logic [7:0] b);
        if (f_cnt < MAXL) begin
            exp_kind.push_back(0);
            exp_val.push_back(int'(b));
            f_cnt++;
        end else begin
            f_err = 1;
        end
        if (b == 8'hC0) begin
            send_byte(8'hDB, 1'b1); send_byte(8'hDC, 1'b1);
        end else if (b == 8'hDB) begin
            send_byte(8'hDB, 1'b1); send_byte(8'hDD, 1'b1);
        end else begin
            send_byte(b, 1'b1);
        end
    endtask

    task automatic tok_badesc(input logic [7:0] x);
        f_err = 1;
        send_byte(8'hDB, 1'b1);
        send_byte(x, 1'b1);
    endtask

    task automatic tok_ferr(input logic [7:0] x);
        f_err = 1;
        send_byte(x, 1'b0);
    endtask

    task automatic tok_end();
        if (f_err != 0) begin
            exp_kind.push_back(2); exp_val.push_back(f_cnt);
        end else if (f_cnt > 0) begin
            exp_kind.push_back(1); exp_val.push_back(f_cnt);
            ack_q.push_back(f_cnt);
        end
        f_cnt = 0;
        f_err = 0;
        send_byte(8'hC0, 1'b1);
    endtask

    task automatic tok_escend();
        exp_kind.push_back(2); exp_val.push_back(f_cnt);
        f_cnt = 0;
        f_err = 0;
        send_byte(8'hDB, 1'b1);
        send_byte(8'hC0, 1'b1);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 3000;
        while ((exp_kind.size() != 0 || ack_q.size() != 0 || tx_busy) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({name, "_drained"}, exp_kind.size() + ack_q.size() + int'(tx_busy), 0);
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        repeat (256) @(negedge clk);

        // Nominal frame: C0 F0 19 DB DC 7F C0
        tok_start(); tok_lit(8'hF0); tok_lit(8'h19); tok_lit(8'hC0); tok_lit(8'h7F); tok_end();
        drain("nominal");

        // Escaped ESC: C0 DB DD C0
        tok_start(); tok_lit(8'hDB); tok_end();
        drain("esc_esc");

        // Bad escape: C0 11 DB 55 22 C0
        tok_start(); tok_lit(8'h11); tok_badesc(8'h55); tok_lit(8'h22); tok_end();
        drain("bad_esc");

        // Framing error: C0 AA <bad stop> C0
        tok_start(); tok_lit(8'hAA); tok_ferr(8'h3C); tok_end();
        drain("framing");

        // Overflow past MAX_LEN
        tok_start();
        for (int i = 0; i < MAXL + 2; i++) tok_lit(8'(8'h30 + i));
        tok_end();
        drain("overflow");

        // Glitch: 10-cycle low pulse
        @(negedge clk);
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        drain("glitch");

        // Reset in the middle of the second byte, line held low across release
        send_byte(8'hC0, 1'b1);
        @(negedge clk);
        rxd = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        tok_start(); tok_lit(8'h42); tok_end();
        drain("after_reset");

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            tok_start();
            for (int t = 0; t < int'($urandom_range(0, 7)); t++) begin
                case ($urandom_range(0, 19))
                    0: begin
                        b = 8'($urandom);
                        while (b == 8'hDC || b == 8'hDD || b == 8'hC0) b = 8'($urandom);
                        tok_badesc(b);
                    end
                    1: tok_ferr(8'($urandom));
                    default: begin
                        case ($urandom_range(0, 4))
                            0: b = 8'hC0;
                            1: b = 8'hDB;
                            2: b = 8'hDC;
                            3: b = 8'hDD;
                            default: b = 8'($urandom);
                        endcase
                        tok_lit(b);
                    end
                endcase
            end
            if ($urandom_range(0, 7) == 0) tok_escend();
            else tok_end();
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
